rx_alu_frame_collector: RTL

//   Parametrised successor of the UART-RX-to-ALU interface. Assembles RX bytes into frames of
//   A operand, B operand and opcode, with operands wider than one byte (multi-byte, LSB first).

---
 rtl/rx_alu_frame_collector.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rx_alu_frame_collector.sv
// Purpose  : assembles UART RX bytes into {A, B, opcode} frames (operands LSB byte first) for the ALU.
// Latency  : o_rx_alu_done / o_err_op pulse 1 cycle after the edge that accepts the opcode byte.
// Backpress: none; bytes are taken on each rising edge of i_done_data, and a stalled frame is dropped on timeout.
//
// Ports:
//   i_clk, i_rst          clock; synchronous reset, active low
//   i_data, i_done_data   RX byte and its byte-done strobe (level, counted once per rising edge)
//   o_a, o_b, o_op        last good frame, held until the next good frame
//   o_rx_alu_done         1-cycle pulse when o_a/o_b/o_op update
//   o_busy                high while a frame is partially received
//   o_err_timeout         1-cycle pulse: partial frame dropped after TIMEOUT_CYC idle cycles
//   o_err_op              1-cycle pulse: frame dropped, opcode byte has bits set above NB_OPERADOR
module rx_alu_frame_collector #(
  parameter int DBIT        = 8,
  parameter int NB_DATA     = 16,
  parameter int NB_OPERADOR = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DBIT-1:0]        i_data,
  input  logic                   i_done_data,
  output logic [NB_DATA-1:0]     o_a,
  output logic [NB_DATA-1:0]     o_b,
  output logic [NB_OPERADOR-1:0] o_op,
  output logic                   o_rx_alu_done,
  output logic                   o_busy,
  output logic                   o_err_timeout,
  output logic                   o_err_op
);

  localparam int N  = NB_DATA / DBIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // The counter only has to hold 0 .. TIMEOUT_CYC-1; expiry is detected on the last value.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [CW-1:0] TO_LAST  = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam bit            TO_EN    = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    ST_A  = 2'd0,
    ST_B  = 2'd1,
    ST_OP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 strobe_q;
  logic [NB_DATA-1:0]   shadow_a_q, shadow_b_q;
  logic [CW-1:0]        cnt_q;

  logic accept;
  logic idx_last;
  logic op_legal;
  logic expire;
  logic frame_ok;
  logic frame_bad;

  assign accept   = i_done_data & ~strobe_q;
  assign idx_last = (idx_q == IDX_LAST);
  assign op_legal = ((i_data >> NB_OPERADOR) == '0);
  // An accepted byte always beats a simultaneous expiry.
  assign expire   = TO_EN && o_busy && !accept && (cnt_q == TO_LAST);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (accept) begin
      case (state_q)
        ST_A: begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_B;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_B: begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_OP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_OP: begin
          state_d   = ST_A;
          idx_d     = '0;
          frame_ok  = op_legal;
          frame_bad = ~op_legal;
        end
        default: begin
          state_d = ST_A;
          idx_d   = '0;
        end
      endcase
    end else if (expire) begin
      state_d = ST_A;
      idx_d   = '0;
    end
  end

  // State register; busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_A;
      idx_q   <= '0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      o_busy  <= (state_d != ST_A) || (idx_d != '0);
    end
  end

  // Datapath: edge register, shadows, idle counter and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      strobe_q      <= 1'b0;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      cnt_q         <= '0;
      o_a           <= '0;
      o_b           <= '0;
      o_op          <= '0;
      o_rx_alu_done <= 1'b0;
      o_err_op      <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      strobe_q      <= i_done_data;
      o_rx_alu_done <= frame_ok;
      o_err_op      <= frame_bad;
      o_err_timeout <= expire;
      if (accept) begin
        cnt_q <= '0;
        case (state_q)
          ST_A:    shadow_a_q[int'(idx_q)*DBIT +: DBIT] <= i_data;
          ST_B:    shadow_b_q[int'(idx_q)*DBIT +: DBIT] <= i_data;
          ST_OP: begin
            if (frame_ok) begin
              o_a  <= shadow_a_q;
              o_b  <= shadow_b_q;
              o_op <= i_data[NB_OPERADOR-1:0];
            end
          end
          default: ;
        endcase
      end else if (expire) begin
        cnt_q      <= '0;
        shadow_a_q <= '0;
        shadow_b_q <= '0;
      end else if (o_busy && TO_EN) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
